cic_feed_pacer: RTL and testbench
=================================

CIC_FEED_PACER -- requirements
Module: cic_feed_pacer

Interface
REQ-001 SHALL have parameter dw, default 16: sample width.
REQ-002 SHALL have parameter aw, default 4: FIFO address width; depth 2**aw = 16.
REQ-003 SHALL have parameter pw, default 8: pacing-period width.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  dw  upstream sample.
REQ-007 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept; transfer occurs when in_valid && in_ready.
REQ-009 SHALL have port enable  input  1  run the pacing strobe.
REQ-010 SHALL have port period  input  pw  output-strobe period in clk cycles.
REQ-011 SHALL have port clr_flags  input  1  one-cycle clear of the sticky underflow flag.
REQ-012 SHALL have port data_out  output  dw  sample to the CIC interpolator's data_in.
REQ-013 SHALL have port data_out_gate  output  1  one-cycle strobe to the CIC interpolator's data_in_gate.
REQ-014 SHALL have port fill  output  aw+1  current FIFO occupancy, 0..2**aw.
REQ-015 SHALL have port underflow  output  1  sticky; a strobe found the FIFO empty.

Function
REQ-016 SHALL implement a 2**aw-entry FIFO; in_ready = (fill != 2**aw).
REQ-017 SHALL write in_data on an accepted transfer; the written word becomes poppable and visible in fill the following cycle.
REQ-018 SHALL use effective period Pe = max(period, 2).
REQ-019 SHALL implement a down-counter: while enable=0, hold it at Pe-1 and emit no ticks.
REQ-020 SHALL, while enable=1, decrement the counter every cycle; at count 0, assert an internal tick and reload Pe-1, giving one tick every Pe cycles.
REQ-021 SHALL produce the first tick Pe cycles after enable rises.
REQ-022 SHALL sample period only at reload, so a mid-interval change takes effect at the next interval.
REQ-023 SHALL, on a tick with fill>0, pop the head word, register it onto data_out and assert data_out_gate for exactly one cycle on the following cycle (latency 1).
REQ-024 SHALL, on a tick with fill=0, still assert data_out_gate for one cycle, keep data_out at its previous value, and set underflow; cadence to the CIC is never broken.
REQ-025 SHALL NOT bypass a word written in the same cycle as a tick on an empty FIFO; the tick counts as an underflow and the word remains queued.
REQ-026 SHALL, on a simultaneous push and pop, leave fill unchanged; when full, the pop's freed slot appears as in_ready=1 the next cycle.
REQ-027 SHALL let pointers wrap modulo 2**aw with no loss or duplication.
REQ-028 SHALL hold data_out between strobes; data_out_gate SHALL never be high on two consecutive cycles.
REQ-029 SHALL clear underflow on clr_flags; if clr_flags coincides with a new underflow event, set SHALL win.
REQ-030 SHALL keep accepting input while enable=0.

Reset
REQ-031 SHALL, while reset=1, force: fill=0, pointers=0, data_out=0, data_out_gate=0, underflow=0, counter=Pe-1, in_ready=0.
REQ-032 SHALL set in_ready=1 on the first cycle after reset deasserts.
REQ-033 SHALL, on reset mid-operation, discard all queued data; the next tick after reset SHALL count as a fresh Pe-cycle interval.

Verification
REQ-034 SHALL verify: period=5, enable=1, push 100,200,300 -> strobes every 5 cycles; data_out=100,200,300; then 300 repeats with underflow=1.
REQ-035 SHALL verify: enable=0, push 17 words -> 16 accepted, in_ready=0, fill=16; enable=1, period=2 -> all 16 drain in order, and in_ready rises one cycle after the first pop.
REQ-036 SHALL verify: period=0 and period=1 -> strobe every 2 cycles, identical to period=2.
REQ-037 SHALL verify: change period 8->3 mid-interval -> the current 8-cycle interval completes, then strobes every 3 cycles.
REQ-038 SHALL verify: underflow set, clr_flags pulsed on the same cycle as another empty tick -> underflow stays 1; a clr_flags pulse with no event -> underflow=0.
REQ-039 SHALL verify: reset pulsed with fill=7 -> fill=0, data_out=0, no strobe until Pe cycles after reset release with enable=1.

Source files
------------

// File: rtl/cic_feed_pacer.sv
// Paced sample feeder for a CIC interpolator: a small FIFO drained by a
// programmable-period strobe that keeps cadence even when the FIFO runs dry.
module cic_feed_pacer #(
    parameter int dw = 16,
    parameter int aw = 4,
    parameter int pw = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [dw-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          enable,
    input  logic [pw-1:0] period,
    input  logic          clr_flags,
    output logic [dw-1:0] data_out,
    output logic          data_out_gate,
    output logic [aw:0]   fill,
    output logic          underflow
);
    localparam int depth = 1 << aw;

    logic [dw-1:0] mem_q [depth];
    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [aw:0]   fill_q, fill_d;
    logic [pw-1:0] cnt_q, cnt_d;
    logic [pw-1:0] pe_m1;
    logic [dw-1:0] data_q, data_d;
    logic          gate_q, gate_d;
    logic          unf_q, unf_d;
    logic          tick, push, pop;

    // Periods below 2 would make the strobe stick high; clamp to 2.
    assign pe_m1    = (period < pw'(2)) ? pw'(1) : period - pw'(1);
    assign in_ready = !reset && (fill_q != (aw+1)'(depth));

    always_comb begin
        tick     = 1'b0;
        cnt_d    = cnt_q;
        push     = in_valid && in_ready;
        pop      = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        data_d   = data_q;
        gate_d   = 1'b0;
        unf_d    = unf_q;

        if (!enable) begin
            cnt_d = pe_m1;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = pe_m1;
        end else begin
            cnt_d = cnt_q - pw'(1);
        end

        // Only words already committed before this edge can be popped.
        pop = tick && (fill_q != '0);

        if (push) wr_ptr_d = wr_ptr_q + aw'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + aw'(1);
            data_d   = mem_q[rd_ptr_q];
        end

        unique case ({push, pop})
            2'b10:   fill_d = fill_q + (aw+1)'(1);
            2'b01:   fill_d = fill_q - (aw+1)'(1);
            default: fill_d = fill_q;
        endcase

        gate_d = tick;
        if (tick && !pop) unf_d = 1'b1;
        else if (clr_flags) unf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            cnt_q    <= pe_m1;
            data_q   <= '0;
            gate_q   <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            gate_q   <= gate_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign data_out      = data_q;
    assign data_out_gate = gate_q;
    assign fill          = fill_q;
    assign underflow     = unf_q;
endmodule

// File: tb/tb_cic_feed_pacer.sv
// Scenario bench for cic_feed_pacer: queue scoreboard for strobed data,
// per-task checks of cadence, fill, ready and the sticky flag.
module tb_cic_feed_pacer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        enable = 1'b0;
    logic [7:0]  period = 8'd5;
    logic        clr_flags = 1'b0;
    logic [15:0] data_out;
    logic        data_out_gate;
    logic [4:0]  fill;
    logic        underflow;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    logic [15:0] exp_q [$];
    int          gates [$];
    logic [15:0] last_d = '0;
    logic        prev_gate = 1'b0;

    cic_feed_pacer #(.dw(16), .aw(4), .pw(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .enable(enable), .period(period), .clr_flags(clr_flags),
        .data_out(data_out), .data_out_gate(data_out_gate),
        .fill(fill), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // One clock; scoreboard the strobe produced by this edge.
    task automatic step();
        logic        acc;
        logic        rst;
        logic [15:0] d;
        logic [15:0] e;
        acc = in_valid && in_ready;
        rst = reset;
        d   = in_data;
        @(posedge clk);
        #1;
        cyc_n++;
        if (data_out_gate) begin
            gates.push_back(cyc_n);
            tests++;
            if (prev_gate) begin
                fails++;
                $display("FAIL gate_double cyc=%0d got two strobes in a row", cyc_n);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                last_d = e;
                if (data_out !== e) begin
                    fails++;
                    $display("FAIL sb_data cyc=%0d got %0d want %0d", cyc_n, data_out, e);
                end
            end else if (data_out !== last_d || underflow !== 1'b1) begin
                fails++;
                $display("FAIL sb_underflow cyc=%0d data %0d want %0d unf %b want 1",
                         cyc_n, data_out, last_d, underflow);
            end
        end
        prev_gate = data_out_gate;
        if (rst) begin
            exp_q.delete();
            last_d = '0;
        end else if (acc) begin
            exp_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        enable = 1'b0;
        clr_flags = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        gates.delete();
    endtask

    // Check that strobes occurred exactly at offsets base+first, +sp, ...
    task automatic check_cadence(string nm, int base, int first, int sp, int n);
        tests++;
        if (gates.size() != n) begin
            fails++;
            $display("FAIL %s_count got %0d strobes want %0d", nm, gates.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (gates[i] - base != first + i * sp) begin
                    fails++;
                    $display("FAIL %s_time strobe %0d at %0d want %0d",
                             nm, i, gates[i] - base, first + i * sp);
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b0 || fill !== 5'd0 || data_out !== 16'd0 ||
            data_out_gate !== 1'b0 || underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_state rdy=%b fill=%0d dout=%0d gate=%b unf=%b want 0s",
                     in_ready, fill, data_out, data_out_gate, underflow);
        end
        reset = 1'b0;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        int base;
        period = 8'd5;
        do_reset();
        in_valid = 1'b1;
        foreach (exp_q[i]) ;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'(i * 100);
            step();
        end
        in_valid = 1'b0;
        tests++;
        if (fill !== 5'd3) begin
            fails++;
            $display("FAIL basic_fill got %0d want 3", fill);
        end
        gates.delete();
        enable = 1'b1;
        base = cyc_n;
        for (int i = 0; i < 26; i++) step();
        check_cadence("basic", base, 5, 5, 5);
        tests++;
        if (underflow !== 1'b1 || data_out !== 16'd300 || fill !== 5'd0) begin
            fails++;
            $display("FAIL basic_end unf=%b dout=%0d fill=%0d want 1/300/0",
                     underflow, data_out, fill);
        end
        enable = 1'b0;
    endtask

    task automatic test_full();
        int base;
        int seen;
        period = 8'd2;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = 16'(1000 + i);
            step();
        end
        in_valid = 1'b0;
        tests++;
        if (fill !== 5'd16 || in_ready !== 1'b0 || exp_q.size() != 16) begin
            fails++;
            $display("FAIL full_state fill=%0d rdy=%b sb=%0d want 16/0/16",
                     fill, in_ready, exp_q.size());
        end
        gates.delete();
        enable = 1'b1;
        base = cyc_n;
        seen = 0;
        for (int i = 0; i < 34; i++) begin
            step();
            if (data_out_gate && seen == 0) begin
                seen = 1;
                tests++;
                if (in_ready !== 1'b1 || fill !== 5'd15) begin
                    fails++;
                    $display("FAIL full_ready rdy=%b fill=%0d want 1/15", in_ready, fill);
                end
            end else if (seen == 0) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL full_ready_early rdy=%b want 0", in_ready);
                end
            end
        end
        check_cadence("full", base, 2, 2, 17);
        tests++;
        if (exp_q.size() != 0 || fill !== 5'd0 || underflow !== 1'b1) begin
            fails++;
            $display("FAIL full_drain sb=%0d fill=%0d unf=%b want 0/0/1",
                     exp_q.size(), fill, underflow);
        end
        enable = 1'b0;
    endtask

    task automatic test_small_period();
        int base;
        for (int p = 0; p < 3; p++) begin
            period = 8'(p);
            do_reset();
            enable = 1'b1;
            base = cyc_n;
            for (int i = 0; i < 13; i++) step();
            check_cadence($sformatf("period%0d", p), base, 2, 2, 6);
            enable = 1'b0;
        end
    endtask

    task automatic test_period_change();
        int base;
        period = 8'd8;
        do_reset();
        enable = 1'b1;
        base = cyc_n;
        for (int i = 0; i < 3; i++) step();
        period = 8'd3;
        for (int i = 0; i < 16; i++) step();
        check_cadence("pchange", base, 8, 3, 4);
        enable = 1'b0;
    endtask

    task automatic test_clr();
        period = 8'd4;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tests++;
        if (data_out_gate !== 1'b1 || underflow !== 1'b1) begin
            fails++;
            $display("FAIL clr_first gate=%b unf=%b want 1/1", data_out_gate, underflow);
        end
        for (int i = 0; i < 3; i++) step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        tests++;
        if (data_out_gate !== 1'b1 || underflow !== 1'b1) begin
            fails++;
            $display("FAIL clr_vs_set gate=%b unf=%b want 1/1", data_out_gate, underflow);
        end
        step();
        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        tests++;
        if (underflow !== 1'b0) begin
            fails++;
            $display("FAIL clr_plain unf=%b want 0", underflow);
        end
        enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        int base;
        period = 8'd6;
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_data = 16'(50 + i);
            step();
        end
        in_valid = 1'b0;
        enable = 1'b1;
        step();
        step();
        tests++;
        if (fill !== 5'd7) begin
            fails++;
            $display("FAIL mid_fill got %0d want 7", fill);
        end
        for (int i = 0; i < 5; i++) step();
        tests++;
        if (data_out !== 16'd50) begin
            fails++;
            $display("FAIL mid_pop got %0d want 50", data_out);
        end
        reset = 1'b1;
        step();
        tests++;
        if (fill !== 5'd0 || data_out !== 16'd0 || data_out_gate !== 1'b0 ||
            in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset fill=%0d dout=%0d gate=%b rdy=%b want 0s",
                     fill, data_out, data_out_gate, in_ready);
        end
        reset = 1'b0;
        gates.delete();
        base = cyc_n;
        for (int i = 0; i < 13; i++) step();
        check_cadence("mid", base, 6, 6, 2);
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_small_period();
        test_period_change();
        test_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end
endmodule
